flight_seq: RTL

- Flight-phase sequencer that drives the altitude and direction command inputs of the drone control top level.
- Accepts high-level operations from the host over a valid/ready handshake: arm, takeoff, land, and timed moves.
- Expands each operation into timed altcmd/dircmd sequences.
- Enforces legal phase ordering and forces motor cut on emergency stop.

---
 rtl/flight_seq.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/flight_seq.sv
// Flight-phase sequencer: expands host arm/takeoff/land/move operations into
// timed altitude and direction commands, with emergency-stop override.
module flight_seq #(
    parameter int TAKEOFF_CYC = 1000,
    parameter int LAND_CYC    = 1500,
    parameter int ARM_TIMEOUT = 50000,
    parameter int DUR_W       = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             estop,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [DUR_W-1:0] cmd_dur,
    output logic             cmd_err,
    output logic [2:0]       altcmd,
    output logic [2:0]       dircmd0,
    output logic [2:0]       dircmd1,
    output logic             armed,
    output logic [2:0]       phase
);

    typedef enum logic [2:0] {
        S_DISARMED = 3'd0,
        S_ARMED    = 3'd1,
        S_TAKEOFF  = 3'd2,
        S_HOVER    = 3'd3,
        S_MANEUVER = 3'd4,
        S_LANDING  = 3'd5,
        S_ESTOP    = 3'd6
    } state_t;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_ARM     = 3'd1;
    localparam logic [2:0] OP_TAKEOFF = 3'd2;
    localparam logic [2:0] OP_LAND    = 3'd3;
    localparam logic [2:0] OP_MOVE_L  = 3'd4;
    localparam logic [2:0] OP_MOVE_R  = 3'd5;
    localparam logic [2:0] OP_MOVE_F  = 3'd6;
    localparam logic [2:0] OP_MOVE_B  = 3'd7;

    localparam logic [2:0] ALT_HOLD    = 3'b000;
    localparam logic [2:0] ALT_CLIMB   = 3'b001;
    localparam logic [2:0] ALT_DESCEND = 3'b010;
    localparam logic [2:0] ALT_CUT     = 3'b100;

    localparam logic [DUR_W-1:0] CNT_TAKEOFF = DUR_W'(TAKEOFF_CYC);
    localparam logic [DUR_W-1:0] CNT_LAND    = DUR_W'(LAND_CYC);
    localparam logic [DUR_W-1:0] CNT_ARM     = DUR_W'(ARM_TIMEOUT);
    localparam logic [DUR_W-1:0] CNT_ONE     = DUR_W'(1);

    state_t           state_q, state_d;
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic [2:0]       move_q, move_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             cmd_err_q, cmd_err_d;
    logic [2:0]       altcmd_q, altcmd_d;
    logic [2:0]       dircmd0_q, dircmd0_d;
    logic [2:0]       dircmd1_q, dircmd1_d;
    logic             armed_q, armed_d;
    logic             xfer;

    assign xfer = cmd_valid && cmd_ready_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        move_d    = move_q;
        cmd_err_d = 1'b0;
        if (estop) begin
            state_d = S_ESTOP;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_DISARMED: begin
                    cnt_d = '0;
                    if (xfer) begin
                        if (cmd_op == OP_ARM) begin
                            state_d = S_ARMED;
                            cnt_d   = CNT_ARM;
                        end else if (cmd_op != OP_NOP) begin
                            cmd_err_d = 1'b1;
                        end
                    end
                end
                // Idle expiry outranks a same-edge command transfer.
                S_ARMED: begin
                    if (cnt_q <= CNT_ONE) begin
                        state_d = S_DISARMED;
                        cnt_d   = '0;
                    end else if (xfer) begin
                        cnt_d = CNT_ARM;
                        case (cmd_op)
                            OP_TAKEOFF: begin
                                state_d = S_TAKEOFF;
                                cnt_d   = CNT_TAKEOFF;
                            end
                            OP_LAND: begin
                                state_d = S_DISARMED;
                                cnt_d   = '0;
                            end
                            OP_NOP, OP_ARM: ;
                            default: cmd_err_d = 1'b1;
                        endcase
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_HOVER: begin
                    cnt_d = '0;
                    if (xfer) begin
                        case (cmd_op)
                            OP_MOVE_L, OP_MOVE_R, OP_MOVE_F, OP_MOVE_B: begin
                                state_d = S_MANEUVER;
                                move_d  = cmd_op;
                                cnt_d   = (cmd_dur == '0) ? CNT_ONE : cmd_dur;
                            end
                            OP_LAND: begin
                                state_d = S_LANDING;
                                cnt_d   = CNT_LAND;
                            end
                            OP_NOP: ;
                            default: cmd_err_d = 1'b1;
                        endcase
                    end
                end
                S_TAKEOFF, S_MANEUVER, S_LANDING: begin
                    if (cnt_q <= CNT_ONE) begin
                        state_d = (state_q == S_LANDING) ? S_DISARMED : S_HOVER;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_DISARMED;
                    cnt_d   = '0;
                end
            endcase
        end

        // Registered outputs are decoded from the state being entered.
        cmd_ready_d = (state_d == S_DISARMED) || (state_d == S_ARMED) || (state_d == S_HOVER);
        armed_d     = (state_d != S_DISARMED) && (state_d != S_ESTOP);
        dircmd0_d   = 3'b000;
        dircmd1_d   = 3'b000;
        case (state_d)
            S_TAKEOFF:             altcmd_d = ALT_CLIMB;
            S_LANDING:             altcmd_d = ALT_DESCEND;
            S_DISARMED, S_ESTOP:   altcmd_d = ALT_CUT;
            default:               altcmd_d = ALT_HOLD;
        endcase
        if (state_d == S_MANEUVER) begin
            case (move_d)
                OP_MOVE_L: dircmd0_d = 3'b001;
                OP_MOVE_R: dircmd0_d = 3'b010;
                OP_MOVE_F: dircmd1_d = 3'b001;
                OP_MOVE_B: dircmd1_d = 3'b010;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_DISARMED;
            cnt_q       <= '0;
            move_q      <= OP_NOP;
            cmd_ready_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            altcmd_q    <= ALT_CUT;
            dircmd0_q   <= 3'b000;
            dircmd1_q   <= 3'b000;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            move_q      <= move_d;
            cmd_ready_q <= cmd_ready_d;
            cmd_err_q   <= cmd_err_d;
            altcmd_q    <= altcmd_d;
            dircmd0_q   <= dircmd0_d;
            dircmd1_q   <= dircmd1_d;
            armed_q     <= armed_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign cmd_err   = cmd_err_q;
    assign altcmd    = altcmd_q;
    assign dircmd0   = dircmd0_q;
    assign dircmd1   = dircmd1_q;
    assign armed     = armed_q;
    assign phase     = state_q;

endmodule
